pe_row_conv_engine: RTL and testbench

- Processing element datapath on the pe_clk side, directly downstream of the cross-clock-domain buffer.
- Consumes the buffer's read strobe (kernel_rden), the ifmap word, the filter word and the incoming partial sum.
- Performs a 1-D row convolution: a filter row is held stationary while the ifmap slides past it.
- Emits one accumulated psum per valid window position, for the write-back path.

---
 rtl/pe_row_conv_engine_pkg.sv | 19 +
 rtl/pe_row_conv_engine_if.sv | 37 +++
 rtl/pe_row_conv_engine_mac.sv | 80 ++++++++
 rtl/pe_row_conv_engine.sv | 158 +++++++++++++++
 tb/tb_pe_row_conv_engine.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_row_conv_engine_pkg.sv
// Shared state encoding and pipeline constants for the PE row-convolution engine.
package pe_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_STREAM,
        ST_DRAIN,
        ST_FINISH
    } pe_conv_state_t;

    localparam int PIPE_LAT = 2;

    function automatic int psum_w(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/pe_row_conv_engine_if.sv
// Buffer-facing config, strobe and data bundle plus the result/status outputs.
// The buffer side drives through master; the engine consumes through slave.
interface pe_row_conv_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int KMAX       = 5,
    parameter int ROW_W      = 10
);
    localparam int KW     = $clog2(KMAX + 1);
    localparam int PSUM_W = pe_conv_pkg::psum_w(DATA_WIDTH);

    logic                  cfg_start;
    logic [KW-1:0]         cfg_kernel_len;
    logic [ROW_W-1:0]      cfg_row_len;
    logic                  kernel_rden;
    logic [DATA_WIDTH-1:0] fltr_data;
    logic [DATA_WIDTH-1:0] ifmap_data;
    logic [PSUM_W-1:0]     psum_in;
    logic [PSUM_W-1:0]     psum_out;
    logic                  psum_valid;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;
    logic                  overrun;

    modport master (
        output cfg_start, cfg_kernel_len, cfg_row_len, kernel_rden,
               fltr_data, ifmap_data, psum_in,
        input  psum_out, psum_valid, busy, done, cfg_err, overrun
    );

    modport slave (
        input  cfg_start, cfg_kernel_len, cfg_row_len, kernel_rden,
               fltr_data, ifmap_data, psum_in,
        output psum_out, psum_valid, busy, done, cfg_err, overrun
    );

endinterface

// File: rtl/pe_row_conv_engine_mac.sv
// K-lane signed multiply (stage 1) then adder tree plus psum_in (stage 2); one issue per cycle.
// Fixed 2-cycle issue-to-valid latency, no stall input; arithmetic wraps at PSUM_W bits.
module pe_mac_pipe
    import pe_conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int KMAX       = 5,
    parameter int KW         = $clog2(KMAX + 1),
    parameter int PSUM_W     = psum_w(DATA_WIDTH)
) (
    input  logic                            pe_clk,
    input  logic                            rstn,
    input  logic                            issue,
    input  logic [KW-1:0]                   klen,
    input  logic [KMAX-1:0][DATA_WIDTH-1:0] taps,
    input  logic [KMAX-1:0][DATA_WIDTH-1:0] window,
    input  logic [PSUM_W-1:0]               psum_in,
    output logic [PSUM_W-1:0]               psum_out,
    output logic                            psum_valid,
    output logic                            drain_ok
);

    logic [KMAX-1:0][PSUM_W-1:0] prod_q, prod_d;
    logic [PSUM_W-1:0]           acc_in_q, acc_in_d;
    logic [PSUM_W-1:0]           psum_q, psum_d;
    logic [PIPE_LAT-1:0]         vld_q, vld_d;
    logic [PSUM_W-1:0]           sum;

    function automatic logic [PSUM_W-1:0] smul(input logic [DATA_WIDTH-1:0] a,
                                               input logic [DATA_WIDTH-1:0] b);
        logic [PSUM_W-1:0] a_ext;
        logic [PSUM_W-1:0] b_ext;
        a_ext = {{(PSUM_W-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
        b_ext = {{(PSUM_W-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
        return a_ext * b_ext;
    endfunction

    always_comb begin
        prod_d   = prod_q;
        acc_in_d = acc_in_q;
        psum_d   = psum_q;
        vld_d    = {vld_q[PIPE_LAT-2:0], issue};
        sum      = acc_in_q;

        if (issue) begin
            acc_in_d = psum_in;
            // window[0] holds the newest pixel, so tap 0 pairs with the newest sample
            for (int k = 0; k < KMAX; k++) begin
                prod_d[k] = (k < int'(klen)) ? smul(taps[k], window[k]) : '0;
            end
        end

        for (int k = 0; k < KMAX; k++) begin
            sum = sum + prod_q[k];
        end
        if (vld_q[0]) begin
            psum_d = sum;
        end
    end

    always_ff @(posedge pe_clk) begin
        if (!rstn) begin
            prod_q   <= '0;
            acc_in_q <= '0;
            psum_q   <= '0;
            vld_q    <= '0;
        end else begin
            prod_q   <= prod_d;
            acc_in_q <= acc_in_d;
            psum_q   <= psum_d;
            vld_q    <= vld_d;
        end
    end

    assign psum_out   = psum_q;
    assign psum_valid = vld_q[PIPE_LAT-1];
    // Only the output stage may still be occupied once the FSM is allowed to finish
    assign drain_ok   = ~|vld_q[PIPE_LAT-2:0];

endmodule

// File: rtl/pe_row_conv_engine.sv
// PE row convolution: load K taps, slide N ifmap pixels past them, emit N-K+1 psums.
// 2-cycle strobe-to-psum latency; no backpressure, kernel_rden gaps of any length hold state.
module pe_row_conv_engine
    import pe_conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int KMAX       = 5,
    parameter int ROW_W      = 10
) (
    input logic                 pe_clk,
    input logic                 rstn,
    pe_row_conv_engine_if.slave bus
);

    localparam int KW     = $clog2(KMAX + 1);
    localparam int PSUM_W = psum_w(DATA_WIDTH);

    pe_conv_state_t                  state_q, state_d;
    logic [KW-1:0]                   k_q, k_d;
    logic [ROW_W-1:0]                n_q, n_d;
    logic [KW-1:0]                   tap_cnt_q, tap_cnt_d;
    logic [ROW_W-1:0]                pix_cnt_q, pix_cnt_d;
    logic [KMAX-1:0][DATA_WIDTH-1:0] taps_q, taps_d;
    logic [KMAX-1:0][DATA_WIDTH-1:0] win_q, win_d;
    logic                            cfg_err_q, cfg_err_d;
    logic                            overrun_q, overrun_d;

    logic             cfg_legal;
    logic [ROW_W-1:0] pix_next;
    logic             issue;
    logic             drain_ok;

    assign cfg_legal = (bus.cfg_kernel_len != '0)
                    && (int'(bus.cfg_kernel_len) <= KMAX)
                    && (int'(bus.cfg_kernel_len) <= int'(bus.cfg_row_len));
    assign pix_next  = pix_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        tap_cnt_d = tap_cnt_q;
        pix_cnt_d = pix_cnt_q;
        taps_d    = taps_q;
        win_d     = win_q;
        cfg_err_d = cfg_err_q;
        overrun_d = overrun_q;
        issue     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.kernel_rden) begin
                    overrun_d = 1'b1;
                end
                if (bus.cfg_start) begin
                    if (cfg_legal) begin
                        k_d       = bus.cfg_kernel_len;
                        n_d       = bus.cfg_row_len;
                        tap_cnt_d = '0;
                        pix_cnt_d = '0;
                        win_d     = '0;
                        cfg_err_d = 1'b0;
                        state_d   = ST_LOAD;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (bus.kernel_rden) begin
                    taps_d[tap_cnt_q] = bus.fltr_data;
                    if (tap_cnt_q == k_q - KW'(1)) begin
                        tap_cnt_d = '0;
                        state_d   = ST_FILL;
                    end else begin
                        tap_cnt_d = tap_cnt_q + 1'b1;
                    end
                end
            end
            ST_FILL, ST_STREAM: begin
                if (bus.kernel_rden) begin
                    win_d     = {win_q[KMAX-2:0], bus.ifmap_data};
                    pix_cnt_d = pix_next;
                    // The strobe that completes the window issues the first MAC itself
                    if (state_q == ST_STREAM || pix_next == ROW_W'(k_q)) begin
                        issue   = 1'b1;
                        state_d = (pix_next == n_q) ? ST_DRAIN : ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.kernel_rden) begin
                    overrun_d = 1'b1;
                end
                if (drain_ok) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (bus.kernel_rden) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pe_clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            tap_cnt_q <= '0;
            pix_cnt_q <= '0;
            taps_q    <= '0;
            win_q     <= '0;
            cfg_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            tap_cnt_q <= tap_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            taps_q    <= taps_d;
            win_q     <= win_d;
            cfg_err_q <= cfg_err_d;
            overrun_q <= overrun_d;
        end
    end

    pe_mac_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .KMAX      (KMAX),
        .KW        (KW),
        .PSUM_W    (PSUM_W)
    ) u_mac (
        .pe_clk    (pe_clk),
        .rstn      (rstn),
        .issue     (issue),
        .klen      (k_q),
        .taps      (taps_q),
        .window    (win_d),
        .psum_in   (bus.psum_in),
        .psum_out  (bus.psum_out),
        .psum_valid(bus.psum_valid),
        .drain_ok  (drain_ok)
    );

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = (state_q == ST_FINISH);
    assign bus.cfg_err = cfg_err_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_pe_row_conv_engine.sv
// Randomised bench for pe_row_conv_engine with an in-bench convolution model and literal pins.
module tb_pe_row_conv_engine;

    localparam int DW    = 16;
    localparam int KMAX  = 5;
    localparam int ROW_W = 10;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_row_conv_engine_if #(.DATA_WIDTH(DW), .KMAX(KMAX), .ROW_W(ROW_W)) bus();

    pe_row_conv_engine #(.DATA_WIDTH(DW), .KMAX(KMAX), .ROW_W(ROW_W)) dut (
        .pe_clk(clk),
        .rstn  (rstn),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state and scoreboard
    logic signed [DW-1:0] tp[KMAX];
    logic signed [DW-1:0] px[64];
    logic [31:0]          ps[64];
    logic [31:0]          exp_val_q[$];
    int                   exp_cyc_q[$];
    logic [31:0]          got_val_q[$];
    int                   got_cyc_q[$];
    int                   exp_done_cyc = -1;

    // Result i of a row is psum_in(at pixel i+K-1) + sum_t tap[t] * pixel[i+K-1-t], mod 2^32
    function automatic logic [31:0] model(input int k, input int i);
        logic [31:0] acc;
        longint      prod;
        acc = ps[i+k-1];
        for (int t = 0; t < k; t++) begin
            prod = longint'(tp[t]) * longint'(px[i+k-1-t]);
            acc  = acc + prod[31:0];
        end
        return acc;
    endfunction

    always @(negedge clk) begin
        logic exp_v;
        while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            check("psum_missing_cycle", 32'(cyc), 32'(exp_cyc_q[0]));
            void'(exp_cyc_q.pop_front());
            void'(exp_val_q.pop_front());
        end
        exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
        check("psum_valid", 32'(bus.psum_valid), 32'(exp_v));
        if (bus.psum_valid) begin
            got_val_q.push_back(bus.psum_out);
            got_cyc_q.push_back(cyc);
        end
        if (exp_v) begin
            check("psum_out", bus.psum_out, exp_val_q[0]);
            void'(exp_cyc_q.pop_front());
            void'(exp_val_q.pop_front());
        end
        check("done", 32'(bus.done), 32'(cyc == exp_done_cyc));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic strobe(input logic [DW-1:0] f, input logic [DW-1:0] x, input logic [31:0] p);
        bus.kernel_rden = 1'b1;
        bus.fltr_data   = f;
        bus.ifmap_data  = x;
        bus.psum_in     = p;
        step();
        bus.kernel_rden = 1'b0;
        bus.fltr_data   = DW'($urandom);
        bus.ifmap_data  = DW'($urandom);
        bus.psum_in     = $urandom;
    endtask

    task automatic start(input int k, input int n);
        bus.cfg_start      = 1'b1;
        bus.cfg_kernel_len = 3'(k);
        bus.cfg_row_len    = ROW_W'(n);
        step();
        bus.cfg_start      = 1'b0;
        bus.cfg_kernel_len = 3'($urandom);
        bus.cfg_row_len    = ROW_W'($urandom);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (bus.busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("row_returns_idle", 32'(bus.busy), 32'd0);
        step();
    endtask

    task automatic run_row(input int k, input int n, input int gmax, input int n_pix);
        got_val_q.delete();
        got_cyc_q.delete();
        start(k, n);
        for (int t = 0; t < k; t++) begin
            idle($urandom_range(0, gmax));
            strobe(tp[t], DW'($urandom), $urandom);
        end
        for (int j = 0; j < n_pix; j++) begin
            idle($urandom_range(0, gmax));
            if (j >= k - 1) begin
                exp_val_q.push_back(model(k, j - k + 1));
                exp_cyc_q.push_back(cyc + 2);
            end
            if (j == n - 1) exp_done_cyc = cyc + 3;
            strobe(DW'($urandom), px[j], ps[j]);
        end
        if (n_pix == n) wait_idle();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        exp_done_cyc = -1;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_psum_valid"}, 32'(bus.psum_valid), 32'd0);
        check({tag, "_psum_out"},   bus.psum_out,        32'd0);
        check({tag, "_busy"},       32'(bus.busy),       32'd0);
        check({tag, "_done"},       32'(bus.done),       32'd0);
        check({tag, "_cfg_err"},    32'(bus.cfg_err),    32'd0);
        check({tag, "_overrun"},    32'(bus.overrun),    32'd0);
        step();
    endtask

    task automatic pin3(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c);
        logic [31:0] lit[3];
        lit[0] = a; lit[1] = b; lit[2] = c;
        check({tag, "_count"}, 32'(got_val_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_val_q.size(); i++) begin
            check({tag, "_value"}, got_val_q[i], lit[i]);
        end
    endtask

    task automatic basic_data(input logic [31:0] p);
        for (int t = 0; t < 3; t++) tp[t] = DW'(t + 1);
        for (int j = 0; j < 5; j++) begin
            px[j] = DW'(j + 1);
            ps[j] = p;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b_vals[$];
        int          k, n;

        bus.cfg_start = 1'b0; bus.cfg_kernel_len = '0; bus.cfg_row_len = '0;
        bus.kernel_rden = 1'b0; bus.fltr_data = '0; bus.ifmap_data = '0; bus.psum_in = '0;
        idle(3);
        rstn = 1'b1;
        check_all_zero("reset");

        // Strobe in IDLE is an overrun
        strobe(16'h1234, 16'h5678, 32'h9abc);
        @(negedge clk);
        check("idle_strobe_overrun", 32'(bus.overrun), 32'd1);
        check("idle_strobe_busy",    32'(bus.busy),    32'd0);
        step();

        // Illegal configurations
        do_reset();
        start(0, 5);
        @(negedge clk);
        check("k0_cfg_err", 32'(bus.cfg_err), 32'd1);
        check("k0_busy",    32'(bus.busy),    32'd0);
        step();
        do_reset();
        start(4, 3);
        @(negedge clk);
        check("k_gt_n_cfg_err", 32'(bus.cfg_err), 32'd1);
        check("k_gt_n_busy",    32'(bus.busy),    32'd0);
        step();
        idle(2);

        // Basic 3-tap row; the legal start also clears the sticky cfg_err
        basic_data(32'd0);
        run_row(3, 5, 0, 5);
        pin3("basic", 32'd10, 32'd16, 32'd22);
        check("basic_cfg_err_cleared", 32'(bus.cfg_err), 32'd0);

        basic_data(32'd100);
        run_row(3, 5, 2, 5);
        pin3("psum_acc", 32'd110, 32'd116, 32'd122);

        // Wrapping arithmetic
        do_reset();
        tp[0] = 16'sh8000; px[0] = 16'sh8000; ps[0] = 32'h7FFF_FFFF;
        run_row(1, 1, 0, 1);
        check("wrap_count", 32'(got_val_q.size()), 32'd1);
        if (got_val_q.size() > 0) check("wrap_value", got_val_q[0], 32'hBFFF_FFFF);
        check("wrap_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("wrap_overrun", 32'(bus.overrun), 32'd0);

        // K=2, N=4 back-to-back, then the same data with random gaps
        for (int t = 0; t < 2; t++) tp[t] = DW'($urandom);
        for (int j = 0; j < 4; j++) begin px[j] = DW'($urandom); ps[j] = $urandom; end
        run_row(2, 4, 0, 4);
        check("b2b_count", 32'(got_cyc_q.size()), 32'd3);
        if (got_cyc_q.size() == 3) begin
            check("b2b_consecutive_1", 32'(got_cyc_q[1] - got_cyc_q[0]), 32'd1);
            check("b2b_consecutive_2", 32'(got_cyc_q[2] - got_cyc_q[1]), 32'd1);
        end
        b2b_vals = got_val_q;
        run_row(2, 4, 7, 4);
        check("gap_count", 32'(got_val_q.size()), 32'(b2b_vals.size()));
        for (int i = 0; i < 3 && i < got_val_q.size() && i < b2b_vals.size(); i++) begin
            check("gap_same_value", got_val_q[i], b2b_vals[i]);
        end

        // Reset in STREAM while the first result is on the output and the second in flight
        basic_data(32'd0);
        run_row(3, 5, 0, 4);
        void'(exp_val_q.pop_back());
        void'(exp_cyc_q.pop_back());
        exp_done_cyc = -1;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check_all_zero("mid_reset");
        idle(6);
        check("mid_reset_one_result", 32'(got_val_q.size()), 32'd1);
        basic_data(32'd0);
        run_row(3, 5, 1, 5);
        pin3("after_reset", 32'd10, 32'd16, 32'd22);

        // Randomised rows
        for (int r = 0; r < 20; r++) begin
            k = $urandom_range(1, KMAX);
            n = $urandom_range(k, k + 10);
            for (int t = 0; t < k; t++) tp[t] = DW'($urandom);
            for (int j = 0; j < n; j++) begin px[j] = DW'($urandom); ps[j] = $urandom; end
            run_row(k, n, (r % 2 == 0) ? 0 : 4, n);
            check("rand_result_count", 32'(got_val_q.size()), 32'(n - k + 1));
        end

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
